fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue_pkg.sv | 13 +
 rtl/fetch_decode_queue_fifo.sv | 54 +++++
 rtl/fetch_decode_queue.sv | 121 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and opcode defaults for the fetch/decode queue slice.
package fetch_decode_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [3:0] DEFAULT_NOP_OP  = 4'b1000;
  localparam logic [3:0] DEFAULT_HALT_OP = 4'b1111;

endpackage

// File: rtl/fetch_decode_queue_fifo.sv
// Small synchronous FIFO with a flush input; pop and push may share an edge when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction fetch from a loadable memory into a decoded-instruction queue,
// with redirect/flush and a halt opcode that stops fetching.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int                INST_CAP = 20,
  parameter int                OP_LEN   = 4,
  parameter int                DATA_LEN = 8,
  parameter int                QDEPTH   = 4,
  parameter logic [OP_LEN-1:0] NOP_OP   = OP_LEN'(DEFAULT_NOP_OP),
  parameter logic [OP_LEN-1:0] HALT_OP  = OP_LEN'(DEFAULT_HALT_OP),
  parameter int                INST_LEN = OP_LEN + DATA_LEN,
  parameter int                PCW      = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                redirect,
  input  logic [PCW-1:0]      redirect_pc,
  input  logic                wr_en,
  input  logic [PCW-1:0]      wr_addr,
  input  logic [INST_LEN-1:0] wr_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_LEN-1:0]   out_op,
  output logic [DATA_LEN-1:0] out_data,
  output logic [PCW-1:0]      out_pc,
  output logic                halted
);

  localparam int AW = $clog2(INST_CAP);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int QW = PCW + INST_LEN;

  fetch_state_t        state;
  logic [PCW-1:0]      fetch_pc;
  logic [PCW-1:0]      rd_pc;
  logic                in_flight;
  logic [INST_LEN-1:0] rd_word;
  logic [INST_LEN-1:0] mem [INST_CAP];

  logic [CW-1:0]       q_count;
  logic                q_full;
  logic                q_empty;
  logic [QW-1:0]       q_dout;
  logic [CW:0]         used;
  logic                rd_is_halt;
  logic                issue;
  logic                pop;
  logic [PCW-1:0]      next_pc;
  logic [PCW-1:0]      redirect_target;

  // Slots already promised to the in-flight read count as occupied.
  assign used            = {1'b0, q_count} + (CW+1)'(in_flight);
  assign rd_is_halt      = in_flight && (rd_word[INST_LEN-1:DATA_LEN] == HALT_OP);
  assign issue           = en && !redirect && (state != HALT) && !rd_is_halt
                           && !q_full && (used < (CW+1)'(QDEPTH));
  assign pop             = out_ready && !q_empty && !redirect;
  assign next_pc         = (fetch_pc == PCW'(INST_CAP - 1)) ? '0 : fetch_pc + PCW'(1);
  assign redirect_target = redirect_pc % PCW'(INST_CAP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      rd_pc     <= '0;
      in_flight <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      state     <= FETCH;
      fetch_pc  <= redirect_target;
      in_flight <= 1'b0;
      halted    <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        rd_pc    <= fetch_pc;
        fetch_pc <= next_pc;
      end
      if (rd_is_halt) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        case (state)
          IDLE:    if (en)  state <= FETCH;
          FETCH:   if (!en) state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

  // Memory contents survive reset; a same-edge write leaves the read with old data.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < PCW'(INST_CAP))) mem[wr_addr[AW-1:0]] <= wr_data;
    if (issue) rd_word <= mem[fetch_pc[AW-1:0]];
  end

  sync_fifo #(
    .WIDTH (QW),
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk   (clk),
    .rstn  (rstn),
    .clear (redirect),
    .push  (in_flight && !redirect),
    .pop   (pop),
    .din   ({rd_pc, rd_word}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign out_valid = !q_empty;
  assign out_op    = q_empty ? NOP_OP : q_dout[DATA_LEN +: OP_LEN];
  assign out_data  = q_empty ? '0 : q_dout[DATA_LEN-1:0];
  assign out_pc    = q_empty ? '0 : q_dout[INST_LEN +: PCW];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue with default parameters.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_op;
  logic [7:0]  out_data;
  logic [5:0]  out_pc;
  logic        halted;

  int pass_count = 0;
  int total_count = 0;

  fetch_decode_queue dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_data    (out_data),
    .out_pc      (out_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] initWord(input int i);
    case (i)
      0:       return 12'h305;
      1:       return 12'h10A;
      2:       return 12'h2FF;
      default: return 12'h500 + 12'(i);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic r, input logic rd, input logic [5:0] rpc);
    en          = e;
    out_ready   = r;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Head compare packs {valid, op, data, pc} into one word.
  task automatic checkHead(input string tag, input logic v, input logic [3:0] op,
                           input logic [7:0] data, input logic [5:0] pc);
    checkOutput(tag, 32'({out_valid, out_op, out_data, out_pc}), 32'({v, op, data, pc}));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      wr_addr = 6'(i);
      wr_data = initWord(i);
      step(1);
    end
    wr_en = 1'b0;
    checkHead("reset_head", 1'b0, 4'h8, 8'h00, 6'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);

    rstn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    step(1); checkHead("startup_c1", 1'b0, 4'h8, 8'h00, 6'd0);
    step(1); checkHead("startup_pc0", 1'b1, 4'h3, 8'h05, 6'd0);
    step(1); checkHead("startup_pc1", 1'b1, 4'h1, 8'h0A, 6'd1);
    step(1); checkHead("startup_pc2", 1'b1, 4'h2, 8'hFF, 6'd2);

    rstn = 1'b0;
    #1;
    checkHead("async_reset", 1'b0, 4'h8, 8'h00, 6'd0);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
    step(2); checkHead("restart_pc0", 1'b1, 4'h3, 8'h05, 6'd0);
    step(8); checkHead("stall_hold", 1'b1, 4'h3, 8'h05, 6'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0);
    step(1); checkHead("drain_pc1", 1'b1, 4'h1, 8'h0A, 6'd1);
    step(1); checkHead("drain_pc2", 1'b1, 4'h2, 8'hFF, 6'd2);
    step(1); checkHead("drain_pc3", 1'b1, 4'h5, 8'h03, 6'd3);
    step(1); checkHead("drain_empty", 1'b0, 4'h8, 8'h00, 6'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    step(1); checkHead("resume_wait", 1'b0, 4'h8, 8'h00, 6'd0);
    step(1); checkHead("resume_pc4", 1'b1, 4'h5, 8'h04, 6'd4);

    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
    step(4); checkHead("full_hold", 1'b1, 4'h5, 8'h04, 6'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd10);
    step(1); checkHead("redirect_flush", 1'b0, 4'h8, 8'h00, 6'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    step(1); checkHead("redirect_gap", 1'b0, 4'h8, 8'h00, 6'd0);
    step(1); checkHead("redirect_pc10", 1'b1, 4'h5, 8'h0A, 6'd10);

    applyStimulus(1'b1, 1'b1, 1'b1, 6'd38);
    wr_en   = 1'b1;
    wr_addr = 6'd3;
    wr_data = 12'hF00;
    step(1);
    wr_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    checkHead("wrap_flush", 1'b0, 4'h8, 8'h00, 6'd0);
    step(2); checkHead("wrap_pc18", 1'b1, 4'h5, 8'h12, 6'd18);
    step(1); checkHead("wrap_pc19", 1'b1, 4'h5, 8'h13, 6'd19);
    step(1); checkHead("wrap_pc0", 1'b1, 4'h3, 8'h05, 6'd0);
    step(1); checkHead("wrap_pc1", 1'b1, 4'h1, 8'h0A, 6'd1);
    step(1); checkHead("wrap_pc2", 1'b1, 4'h2, 8'hFF, 6'd2);
    step(1); checkHead("halt_pc3", 1'b1, 4'hF, 8'h00, 6'd3);
    checkOutput("halt_flag_set", 32'(halted), 32'd1);
    step(1); checkHead("halt_empty", 1'b0, 4'h8, 8'h00, 6'd0);
    checkOutput("halt_flag_hold", 32'(halted), 32'd1);
    step(1); checkHead("halt_no_pc4", 1'b0, 4'h8, 8'h00, 6'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 6'd7);
    step(1);
    checkOutput("halt_cleared", 32'(halted), 32'd0);
    checkHead("halt_redirect_flush", 1'b0, 4'h8, 8'h00, 6'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    wr_en   = 1'b1;
    wr_addr = 6'd7;
    wr_data = 12'h6AA;
    step(1);
    wr_en = 1'b0;
    checkHead("halt_redirect_gap", 1'b0, 4'h8, 8'h00, 6'd0);
    step(1); checkHead("halt_redirect_pc7_old", 1'b1, 4'h5, 8'h07, 6'd7);

    applyStimulus(1'b1, 1'b1, 1'b1, 6'd7);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    step(2); checkHead("rewrite_pc7_new", 1'b1, 4'h6, 8'hAA, 6'd7);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
